mem_stage: RTL

Memory-access stage of the five-stage MIPS pipeline, directly downstream of the execute stage. Holds the EX/MEM and MEM/WB pipeline registers, drives a single-port data-memory request/acknowledge interface, performs byte/halfword lane steering and load extension, and stalls the pipeline while an access is outstanding. Its M- and W-side register outputs feed the forwarding unit and the register-file write port.

---
 rtl/mips_pkg.sv | 49 ++++
 rtl/mem_stage_if.sv | 21 ++
 rtl/mem_align.sv | 51 +++++
 rtl/mem_stage.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory stage: opcodes, FSM states, access sizes
// and the EX/MEM and MEM/WB pipeline register layouts.
package mips_pkg;

  localparam logic [5:0] OpLb  = 6'h20;
  localparam logic [5:0] OpLh  = 6'h21;
  localparam logic [5:0] OpLw  = 6'h23;
  localparam logic [5:0] OpLbu = 6'h24;
  localparam logic [5:0] OpLhu = 6'h25;
  localparam logic [5:0] OpSb  = 6'h28;
  localparam logic [5:0] OpSh  = 6'h29;
  localparam logic [5:0] OpSw  = 6'h2B;

  typedef enum logic [0:0] {StIdle, StWait} mem_state_e;

  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} acc_size_e;

  typedef struct packed {
    logic [31:0] alu_out;
    logic [31:0] store_data;
    logic [4:0]  r3_addr;
    logic [5:0]  op;
    logic        reg_write;
    logic        memto_reg;
    logic        mem_write;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] alu_out;
    logic [31:0] readdata;
    logic [4:0]  r3_addr;
    logic        reg_write;
    logic        memto_reg;
    logic        align_err;
  } mem_wb_t;

  function automatic acc_size_e op_size(input logic [5:0] op);
    case (op)
      OpLb, OpLbu, OpSb: op_size = SzByte;
      OpLh, OpLhu, OpSh: op_size = SzHalf;
      default:           op_size = SzWord;
    endcase
  endfunction

  function automatic logic op_unsigned(input logic [5:0] op);
    op_unsigned = (op == OpLbu) || (op == OpLhu);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Single-port data-memory request/acknowledge bus between mem_stage (master)
// and the data memory (slave).
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_align.sv
// Combinational lane logic: store byte enables and data replication, load lane
// selection with sign/zero extension (little-endian byte numbering).
module mem_align
  import mips_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  acc_size_e   size;
  logic        is_unsigned;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    size        = op_size(op_i);
    is_unsigned = op_unsigned(op_i);
    byte_lane   = rdata_i[7:0];
    unique case (addr_lo_i)
      2'd0: byte_lane = rdata_i[7:0];
      2'd1: byte_lane = rdata_i[15:8];
      2'd2: byte_lane = rdata_i[23:16];
      2'd3: byte_lane = rdata_i[31:24];
    endcase
    // Halfword lane ignores addr[0]; misalignment is handled upstream.
    half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    be_o        = 4'b1111;
    wdata_o     = store_data_i;
    load_data_o = rdata_i;
    case (size)
      SzByte: begin
        be_o        = 4'b0001 << addr_lo_i;
        wdata_o     = {4{store_data_i[7:0]}};
        load_data_o = is_unsigned ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      end
      SzHalf: begin
        be_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o     = {2{store_data_i[15:0]}};
        load_data_o = is_unsigned ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: EX/MEM and MEM/WB registers, data-memory handshake,
// stall generation. Define MEM_ALIGN_CHECK_EN to trap misaligned half/word accesses.
module mem_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_outE,
  input  logic [31:0] r2_doutEC,
  input  logic [4:0]  r3_addrE,
  input  logic [5:0]  opE,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  output logic [31:0] alu_outM,
  output logic [4:0]  r3_addrM,
  output logic        RegWriteM,
  output logic        MemtoRegM,
  output logic        stallM,
  mem_stage_if.master dmem,
  output logic [31:0] alu_outW,
  output logic [31:0] readdataW,
  output logic [4:0]  r3_addrW,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic        align_errW
);

  ex_mem_t    m_d, m_q;
  mem_wb_t    w_d, w_q;
  mem_state_e state_d, state_q;

  logic        mem_op;
  logic        misalign;
  logic        mem_req;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] load_data;

  assign mem_op = m_q.memto_reg | m_q.mem_write;

`ifdef MEM_ALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    if (mem_op) begin
      case (op_size(m_q.op))
        SzHalf:  misalign = m_q.alu_out[0];
        SzWord:  misalign = |m_q.alu_out[1:0];
        default: misalign = 1'b0;
      endcase
    end
  end
`else
  assign misalign = 1'b0;
`endif

  assign mem_req = mem_op & ~misalign;
  assign stallM  = mem_req & ~dmem.dmem_ack;

  mem_align u_mem_align (
    .op_i         (m_q.op),
    .addr_lo_i    (m_q.alu_out[1:0]),
    .store_data_i (m_q.store_data),
    .rdata_i      (dmem.dmem_rdata),
    .be_o         (be),
    .wdata_o      (wdata),
    .load_data_o  (load_data)
  );

  always_comb begin
    m_d = m_q;
    if (!stallM) begin
      m_d.alu_out    = alu_outE;
      m_d.store_data = r2_doutEC;
      m_d.r3_addr    = r3_addrE;
      m_d.op         = opE;
      m_d.reg_write  = RegWriteE;
      m_d.memto_reg  = MemtoRegE;
      m_d.mem_write  = MemWriteE;
    end
  end

  // Data fields load every cycle; only the control bits are squashed on a stall.
  always_comb begin
    w_d.alu_out   = m_q.alu_out;
    w_d.readdata  = load_data;
    w_d.r3_addr   = m_q.r3_addr;
    w_d.reg_write = m_q.reg_write & ~misalign & ~stallM;
    w_d.memto_reg = m_q.memto_reg & ~misalign & ~stallM;
    w_d.align_err = misalign & ~stallM;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (mem_req && !dmem.dmem_ack) state_d = StWait;
      StWait: if (dmem.dmem_ack) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q     <= '0;
      w_q     <= '0;
      state_q <= StIdle;
    end else begin
      m_q     <= m_d;
      w_q     <= w_d;
      state_q <= state_d;
    end
  end

  assign dmem.dmem_req   = mem_req;
  assign dmem.dmem_we    = mem_req & m_q.mem_write;
  assign dmem.dmem_addr  = {m_q.alu_out[31:2], 2'b00};
  assign dmem.dmem_be    = be;
  assign dmem.dmem_wdata = wdata;

  assign alu_outM   = m_q.alu_out;
  assign r3_addrM   = m_q.r3_addr;
  assign RegWriteM  = m_q.reg_write;
  assign MemtoRegM  = m_q.memto_reg;

  assign alu_outW   = w_q.alu_out;
  assign readdataW  = w_q.readdata;
  assign r3_addrW   = w_q.r3_addr;
  assign RegWriteW  = w_q.reg_write;
  assign MemtoRegW  = w_q.memto_reg;
  assign align_errW = w_q.align_err;

endmodule
